// File: rtl/apb_arb_pkg.sv
// Shared types and helpers for the APB master arbiter.
// Build option: APB_ARB_TIMEOUT_EN, which enables the ACCESS-phase timeout in apb_master_arbiter.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam int MAX_REQ            = 8;
    localparam int IDX_W              = 3;
    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_ADDR_W         = 32;
    localparam int DEF_DATA_W         = 32;
    localparam int DEF_TIMEOUT_CYCLES = 256;

    // True when requester index idx selects one-hot bit position pos.
    function automatic logic is_index(input logic [IDX_W-1:0] idx, input int pos);
        return int'(idx) == pos;
    endfunction

    // Round-robin successor of idx among n requesters.
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx, input int n);
        return (int'(idx) >= n - 1) ? '0 : idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping at NUM_REQ-1.
module rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    always_comb begin
        idx   = '0;
        any   = 1'b0;
        grant = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!any && req[i] && (((int'(ptr) + off) % NUM_REQ) == i)) begin
                    any = 1'b1;
                    idx = IDX_W'(i);
                end
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = any && is_index(idx, i);
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin APB master shared by NUM_REQ requesters; one SETUP/ACCESS transfer at a time.
// Build option: APB_ARB_TIMEOUT_EN aborts ACCESS after TIMEOUT_CYCLES wait cycles with rsp_err=1.
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                      clk,
    input  logic                      RESET,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic [NUM_REQ-1:0]        req_write,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic [ADDR_W-1:0]         PADDR,
    output logic [DATA_W-1:0]         PWDATA,
    output logic                      PWRITE,
    output logic                      PSELx,
    output logic                      PENABLE,
    input  logic                      PREADY,
    input  logic [DATA_W-1:0]         PRDATA,
    output state_t                    dbg_state
);

    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("apb_master_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    // Handshake: req_ready[i] is high only in an IDLE cycle where requester i wins; the command
    // on req_* is captured at that clock edge and later changes on req_* are ignored.
    // rsp_valid[i] is a one-cycle pulse with no back-pressure.

    state_t               state, next_state;
    logic [IDX_W-1:0]     ptr, cmd_idx, win_idx;
    logic [NUM_REQ-1:0]   win_grant, rsp_oh, rsp_valid_q;
    logic                 win_any, accept, done, timeout_hit;
    logic [ADDR_W-1:0]    cmd_addr, sel_addr;
    logic [DATA_W-1:0]    cmd_wdata, sel_wdata, rsp_rdata_q;
    logic                 cmd_write, sel_write;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (win_grant),
        .idx   (win_idx),
        .any   (win_any)
    );

`ifdef APB_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] wait_cnt;
    logic            rsp_err_q;

    // Counts ACCESS cycles with PREADY low; the TIMEOUT_CYCLES-th such cycle ends the transfer.
    always_ff @(posedge clk) begin
        if (RESET || accept) begin
            wait_cnt <= '0;
        end else if (state == ACCESS && !PREADY) begin
            wait_cnt <= wait_cnt + TO_W'(1);
        end
    end

    assign timeout_hit = (state == ACCESS) && !PREADY && (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (RESET) begin
            rsp_err_q <= 1'b0;
        end else begin
            rsp_err_q <= timeout_hit;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign timeout_hit = 1'b0;
    assign rsp_err     = 1'b0;
`endif

    assign done = (state == ACCESS) && (PREADY || timeout_hit);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM: next state
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (win_any) next_state = SETUP;
            SETUP:   next_state = ACCESS;
            ACCESS:  if (done) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        PSELx     = (state == SETUP) || (state == ACCESS);
        PENABLE   = (state == ACCESS);
        accept    = (state == IDLE) && win_any;
        req_ready = accept ? win_grant : '0;
        dbg_state = state;
    end

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_grant[i]) begin
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
                sel_write = req_write[i];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_oh[i] = is_index(cmd_idx, i);
        end
    end

    // Command latch doubles as the APB address/data/control registers, so they hold in IDLE.
    always_ff @(posedge clk) begin
        if (RESET) begin
            ptr       <= '0;
            cmd_idx   <= '0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            cmd_write <= 1'b0;
        end else if (accept) begin
            ptr       <= wrap_inc(win_idx, NUM_REQ);
            cmd_idx   <= win_idx;
            cmd_addr  <= sel_addr;
            cmd_wdata <= sel_wdata;
            cmd_write <= sel_write;
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= done ? rsp_oh : '0;
            rsp_rdata_q <= (done && PREADY && !cmd_write) ? PRDATA : '0;
        end
    end

    assign PADDR     = cmd_addr;
    assign PWDATA    = cmd_wdata;
    assign PWRITE    = cmd_write;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
